if_id: RTL
==========

Name: if_id

Overview:
- Instruction buffer and pipeline register between the fetch stage (pc + instruction memory) and the decode stage.
- Captures {pc, inst} pairs from fetch into a small FIFO and presents them to decode using a valid/ready handshake.
- Absorbs decode back-pressure and applies the core's hold codes and jump flush.
- Guarantees that no instruction fetched before a taken jump reaches decode.

Parameters:
- DEPTH, 2, buffer entries; power of two, ≥2
- NOP_INST, 32'h00000013, value driven on inst_o when the buffer is empty or in reset

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- pc_i  input  `INST_ADDR_WIDTH  address of the fetched instruction
- inst_i  input  `INST_WIDTH  fetched instruction word
- f_valid_i  input  1  pc_i/inst_i valid this cycle
- f_ready_o  output  1  buffer can accept a push
- jump  input  1  flush request, active when == `JUMP
- hold  input  2  hold code (see Behaviour)
- id_ready_i  input  1  decode accepts the head entry
- id_valid_o  output  1  head entry valid for decode
- pc_o  output  `INST_ADDR_WIDTH  head entry pc
- inst_o  output  `INST_WIDTH  head entry instruction
- count_o  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst==0, asynchronous):
  - rd/wr pointers = 0, count_o = 0.
  - id_valid_o = 0, pc_o = `INI_INST_ADDR, inst_o = NOP_INST.
  - f_ready_o = 0 while rst is low.
- Reset release: f_ready_o = 1 in the first cycle after release. Storage contents need no reset.
- Hold codes (constants in defines.v):
  - 2'b00 HOLD_NONE: no effect.
  - 2'b01 `HOLD (pc stall): no effect on this block.
  - 2'b10 HOLD_IF: push blocked.
  - 2'b11 HOLD_ID: push and pop both blocked.
- Combinational outputs:
  - full = (count_o == DEPTH); empty = (count_o == 0).
  - f_ready_o = rst && !full && hold∉{HOLD_IF, HOLD_ID} && jump != `JUMP. No combinational path from id_ready_i.
  - id_valid_o = !empty && jump != `JUMP && hold != HOLD_ID.
  - pc_o/inst_o = head entry when !empty; otherwise last popped pc and NOP_INST.
- push = f_valid_i && f_ready_o: writes {pc_i, inst_i} at wr_ptr, then wr_ptr+1.
- pop = id_valid_o && id_ready_i: rd_ptr+1.
- Push and pop in the same cycle: count unchanged. Legal whenever not full. When full, push is refused even if a pop occurs.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally. full/empty come from count_o, not pointer compare.
- Latency: an entry pushed at edge N is visible on id_valid_o/pc_o/inst_o after edge N (1 cycle). There is no fetch→decode bypass.
- Flush (jump == `JUMP):
  - Outputs are masked in the same cycle.
  - At the next edge: count = 0, rd_ptr = wr_ptr, pc_o holds its last value, inst_o = NOP_INST.
  - Flush has priority over hold and over push.
- Overflow/underflow are impossible by construction. Push when full or pop when empty is ignored and must not change any state.
- Reset asserted mid-operation clears everything immediately, including during a flush or hold.

Decomposition:
- defines.v gains: HOLD_NONE, HOLD_IF, HOLD_ID, NOP_INST default, IF_ID_DEPTH. It reuses `INST_ADDR_WIDTH, `INST_WIDTH, `INI_INST_ADDR, `JUMP, `HOLD.
- One sub-module, if_id_buf: a generic DEPTH×(addr+inst) register file with write port and async read. if_id holds the pointers, count and control.

Test Plan:
- Reset/idle: rst low → id_valid_o=0, inst_o=32'h00000013, pc_o=`INI_INST_ADDR, f_ready_o=0. Release rst → f_ready_o=1 next cycle.
- Streaming: push pc 0x0,0x4,0x8 with id_ready_i=1 every cycle → each appears one cycle after push, in order; count_o ≤ 1.
- Back-pressure: id_ready_i=0, push 0x0,0x4,0x8 → count_o reaches 2, f_ready_o=0, 0x8 not accepted. Raise id_ready_i → 0x0 then 0x4 drain, then f_ready_o=1.
- Flush: buffer holds 0x10,0x14; assert jump with f_valid_i=1 (pc 0x18) → id_valid_o=0 that cycle, count_o=0 next cycle, 0x18 never appears. Push 0x80 → appears next cycle.
- Holds:
  - hold=2'b11 with 2 entries and id_ready_i=1 → no pop, no push, count stays 2.
  - hold=2'b10 → pops continue, pushes refused.
  - hold=2'b01 → normal streaming.
- Mid-operation reset: count_o=2, pull rst low between edges → id_valid_o=0 and count_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_pkg.sv
// if_id_pkg
// Shared constants and types for the fetch/decode instruction buffer.
// Mirrors the core-wide defines (address/instruction widths, reset pc,
// jump and hold encodings) so the buffer, its storage and the bench all
// agree on one set of values.
package if_id_pkg;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_WIDTH      = 32;

  localparam logic [INST_ADDR_WIDTH-1:0] INI_INST_ADDR = '0;

  // Jump flush is requested when the jump line equals this value.
  localparam logic JUMP = 1'b1;

  // Default buffer depth and the instruction shown when nothing is valid
  // (addi x0, x0, 0).
  localparam int                    IF_ID_DEPTH      = 2;
  localparam logic [INST_WIDTH-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // Hold codes driven by the core's hazard control. HOLD only stalls the
  // pc and has no effect here; HOLD_IF blocks pushes; HOLD_ID blocks both
  // pushes and pops.
  typedef enum logic [1:0] {
    HOLD_NONE = 2'b00,
    HOLD      = 2'b01,
    HOLD_IF   = 2'b10,
    HOLD_ID   = 2'b11
  } hold_e;

endpackage

// File: rtl/if_id_buf.sv
// if_id_buf
// Generic DEPTH-entry storage of {pc, inst} pairs with one synchronous
// write port and one asynchronous read port. No reset: the owner tracks
// which entries are valid.
// Ports:
//   clk          write clock
//   we           write enable
//   waddr        write index
//   wpc, winst   data written at waddr
//   raddr        read index
//   rpc, rinst   data currently stored at raddr
module if_id_buf #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int IW    = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [AW-1:0] wpc,
  input  logic [IW-1:0] winst,
  input  logic [PW-1:0] raddr,
  output logic [AW-1:0] rpc,
  output logic [IW-1:0] rinst
);

  logic [AW-1:0] pc_mem   [DEPTH];
  logic [IW-1:0] inst_mem [DEPTH];

  // Entry write; contents are meaningless until the owner marks them valid.
  always_ff @(posedge clk) begin
    if (we) begin
      pc_mem[waddr]   <= wpc;
      inst_mem[waddr] <= winst;
    end
  end

  assign rpc   = pc_mem[raddr];
  assign rinst = inst_mem[raddr];

endmodule

// File: rtl/if_id.sv
// if_id
// Instruction buffer and pipeline register between fetch and decode.
// Fetch pushes {pc, inst} pairs into a small FIFO; decode pops them via a
// valid/ready handshake. Hold codes stall pushes and/or pops, and a taken
// jump discards everything buffered so no wrong-path instruction reaches
// decode.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   pc_i, inst_i, f_valid_i  fetched pair and its valid
//   f_ready_o              buffer accepts a push this cycle
//   jump, hold             flush request and hold code
//   id_ready_i             decode accepts the head entry
//   id_valid_o, pc_o, inst_o  head entry presented to decode
//   count_o                current occupancy
module if_id
  import if_id_pkg::*;
#(
  parameter int                    DEPTH    = IF_ID_DEPTH,
  parameter logic [INST_WIDTH-1:0] NOP_INST = NOP_INST_DEFAULT,
  parameter int                    CW       = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_ADDR_WIDTH-1:0] pc_i,
  input  logic [INST_WIDTH-1:0]      inst_i,
  input  logic                       f_valid_i,
  output logic                       f_ready_o,
  input  logic                       jump,
  input  logic [1:0]                 hold,
  input  logic                       id_ready_i,
  output logic                       id_valid_o,
  output logic [INST_ADDR_WIDTH-1:0] pc_o,
  output logic [INST_WIDTH-1:0]      inst_o,
  output logic [CW-1:0]              count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0]              rd_ptr;
  logic [CW-1:0]              wr_ptr;
  logic [CW-1:0]              count;
  logic [INST_ADDR_WIDTH-1:0] last_pc;
  logic [INST_ADDR_WIDTH-1:0] head_pc;
  logic [INST_WIDTH-1:0]      head_inst;
  logic                       full;
  logic                       empty;
  logic                       flush;
  logic                       push_blocked;
  logic                       pop_blocked;
  logic                       push;
  logic                       pop;

  assign flush        = (jump == JUMP);
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign push_blocked = (hold == HOLD_IF) || (hold == HOLD_ID);
  assign pop_blocked  = (hold == HOLD_ID);

  // f_ready_o deliberately ignores id_ready_i: a full buffer refuses a push
  // even when decode pops in the same cycle, keeping fetch timing free of
  // any decode-side combinational path.
  assign f_ready_o  = rst && !full && !push_blocked && !flush;
  assign id_valid_o = !empty && !flush && !pop_blocked;

  assign push = f_valid_i && f_ready_o;
  assign pop  = id_valid_o && id_ready_i;

  if_id_buf #(
    .DEPTH (DEPTH),
    .AW    (INST_ADDR_WIDTH),
    .IW    (INST_WIDTH)
  ) u_buf (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[PW-1:0]),
    .wpc   (pc_i),
    .winst (inst_i),
    .raddr (rd_ptr[PW-1:0]),
    .rpc   (head_pc),
    .rinst (head_inst)
  );

  // When nothing is buffered, decode sees the last pc it consumed (or the
  // reset pc) paired with a NOP, so downstream pc-relative logic stays sane.
  assign pc_o    = empty ? last_pc  : head_pc;
  assign inst_o  = empty ? NOP_INST : head_inst;
  assign count_o = count;

  // Pointer/occupancy update. A flush drops every buffered entry by snapping
  // the read pointer onto the write pointer, and freezes pc_o at whatever it
  // showed during the flush cycle. Push/pop cannot happen during a flush
  // because both handshakes are masked by it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      last_pc <= INI_INST_ADDR;
    end else if (flush) begin
      rd_ptr  <= wr_ptr;
      count   <= '0;
      last_pc <= pc_o;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + CW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + CW'(1);
        last_pc <= head_pc;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule
